// File: rtl/enum_grant_sched.sv
// Round-robin scheduler granting one downstream valid/ready resource to NREQ requesters.
// A grant lasts until the owner drops its request or MAX_BEATS beats are accepted,
// followed by a single DONE cycle that advances the round-robin pointer.
module enum_grant_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    res_ready,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    res_valid,
  output logic [7:0]              beat_cnt,
  output logic [1:0]              state_o,
  output logic [31:0]             state_bits,
  output logic [31:0]             id_bits
);

  localparam int unsigned IdW      = $clog2(NREQ);
  localparam logic [7:0]  LastBeat = 8'(MAX_BEATS - 1);
  localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IdW-1:0] id_q, id_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           found;
  logic [IdW-1:0] win;

  // State and datapath registers; reset drops any grant in flight without a DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round-robin search: first set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[IdW'(idx)]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          id_d    = win;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        // A beat accepted on the exit edge still counts.
        if (res_ready) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!req[id_q] || (res_ready && (cnt_q == LastBeat))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = (id_q == LastId) ? '0 : id_q + IdW'(1);
        state_d = StIdle;
      end
      default: begin
        // Unreachable encoding recovers to idle.
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    gnt       = '0;
    res_valid = 1'b0;
    if (state_q == StBusy) begin
      gnt[id_q] = 1'b1;
      res_valid = 1'b1;
    end
    gnt_id   = id_q;
    beat_cnt = cnt_q;
    state_o  = state_q;
  end

  assign state_bits = 32'($bits(state_t));
  assign id_bits    = 32'(IdW);

endmodule

// File: tb/tb_enum_grant_sched.sv
// Bench for enum_grant_sched: directed stimulus pushes each expected completed grant
// (winner id, final beat count) into a scoreboard; a monitor pops on every DONE cycle.
module tb_enum_grant_sched;

  localparam int unsigned NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic            res_ready;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            res_valid;
  logic [7:0]      beat_cnt;
  logic [1:0]      state_o;
  logic [31:0]     state_bits;
  logic [31:0]     id_bits;

  typedef struct {
    int id;
    int beats;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_state = 2'd0;

  enum_grant_sched #(.NREQ(NREQ), .MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .res_ready  (res_ready),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .res_valid  (res_valid),
    .beat_cnt   (beat_cnt),
    .state_o    (state_o),
    .state_bits (state_bits),
    .id_bits    (id_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d grants outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every DONE cycle must match the oldest expected grant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_state == 2'd2) chk("done_one_cycle", 32'(state_o), 32'd0);
      chk("gnt_onehot", 32'($countones(gnt)), (state_o == 2'd1) ? 32'd1 : 32'd0);
      chk("state_bits", state_bits, 32'd2);
      chk("id_bits", id_bits, 32'd2);
      if (state_o == 2'd2) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got id %0d beats %0d expected no grant", gnt_id,
                   beat_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", 32'(gnt_id), 32'(e.id));
          chk("sb_beats", 32'(beat_cnt), 32'(e.beats));
        end
      end
      prev_state = state_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset with all requests high.
    rst = 1'b1;
    req = 4'b1111;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_state_bits", state_bits, 32'd2);
    chk("rst_id_bits", id_bits, 32'd2);
    mon_en = 1'b1;

    // 2. Single requester, full burst.
    sb.push_back('{id: 2, beats: 8});
    rst = 1'b0;
    req = 4'b0100;
    res_ready = 1'b1;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'd2);
    chk("single_beat0", 32'(beat_cnt), 32'd0);
    repeat (8) tick();
    chk("single_done", 32'(state_o), 32'd2);
    chk("single_beats", 32'(beat_cnt), 32'd8);
    req = 4'b0000;
    tick();
    chk("single_idle", 32'(state_o), 32'd0);

    // 3. Round robin from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    sb.push_back('{id: 0, beats: 8});
    sb.push_back('{id: 1, beats: 8});
    sb.push_back('{id: 2, beats: 8});
    sb.push_back('{id: 3, beats: 8});
    sb.push_back('{id: 0, beats: 8});
    drain(100);
    req = 4'b0000;

    // 4. Early release of id 1 with a beat on the exit edge; pointer moves to 2.
    sb.push_back('{id: 1, beats: 4});
    req = 4'b1010;
    tick();
    chk("early_id", 32'(gnt_id), 32'd1);
    repeat (3) tick();
    chk("early_beat3", 32'(beat_cnt), 32'd3);
    req = 4'b1001;
    tick();
    chk("early_done", 32'(state_o), 32'd2);
    chk("early_beats", 32'(beat_cnt), 32'd4);
    tick();
    chk("early_idle", 32'(state_o), 32'd0);
    tick();
    chk("next_search_id", 32'(gnt_id), 32'd3);
    chk("next_search_gnt", 32'(gnt), 32'h8);

    // 5. Backpressure holds the count and the grant.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_beat", 32'(beat_cnt), 32'd0);
      chk("bp_gnt", 32'(gnt), 32'h8);
    end
    res_ready = 1'b1;
    repeat (5) tick();
    chk("bp_resume", 32'(beat_cnt), 32'd5);
    chk("bp_state", 32'(state_o), 32'd1);

    // 6. Reset mid-grant: no DONE, pointer back to 0.
    rst = 1'b1;
    req = 4'b1000;
    tick();
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_beat", 32'(beat_cnt), 32'd0);
    chk("midrst_id", 32'(gnt_id), 32'd0);
    rst = 1'b0;
    sb.push_back('{id: 3, beats: 8});
    tick();
    chk("postrst_gnt", 32'(gnt), 32'h8);
    chk("postrst_id", 32'(gnt_id), 32'd3);
    drain(40);
    req = 4'b0000;
    repeat (2) tick();
    chk("final_idle", 32'(state_o), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
